// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned multiplier (MULTU) with a HiLo result register.
// It uses shift-add, one multiplier bit per clock, and reads the result back through MFHI/MFLO.
module multu_hilo #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WRITE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2*WIDTH:0] product;
    logic [2*WIDTH:0] step;
    logic [WIDTH:0]   upper_sum;
    logic [CW-1:0]    count;

    // The extra top bit holds the carry, so an all-ones by all-ones product stays exact.
    always_comb begin
        upper_sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        step      = product[0] ? {upper_sum, product[WIDTH-1:0]} : product;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mcand   <= '0;
            product <= '0;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (Signal == MULTU)) begin
                        mcand   <= dataA;
                        product <= {1'b0, {WIDTH{1'b0}}, dataB};
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    product <= step >> 1;
                    count   <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    hi    <= product[2*WIDTH-1:WIDTH];
                    lo    <= product[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (Signal == MFHI) begin
            dataOut = hi;
        end else if (Signal == MFLO) begin
            dataOut = lo;
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo.
// Expected products are queued when a multiply is requested and compared when done pulses.
module tb_multu_hilo;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] ADD   = 6'b100000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int          checks;
    int          failures;
    int          done_count;
    logic [63:0] exp_q[$];

    multu_hilo dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .dataOut(dataOut),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done) done_count++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives a request on the edge that follows and returns at the negedge after that edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                                 input bit accepted);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = sig;
        start  = 1'b1;
        if (accepted) exp_q.push_back({32'b0, a} * {32'b0, b});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic readHiLo(input string tag, input logic [63:0] expected);
        Signal = MFHI;
        #1;
        checkOutput({tag, "_hi"}, {32'b0, dataOut}, {32'b0, expected[63:32]});
        Signal = MFLO;
        #1;
        checkOutput({tag, "_lo"}, {32'b0, dataOut}, {32'b0, expected[31:0]});
    endtask

    // Waits for done while counting busy cycles, then pops and compares.
    // With chain set, the next multiply is requested during the done cycle.
    task automatic waitResult(input string tag, input int exp_busy, input bit chain,
                              input logic [31:0] na, input logic [31:0] nb);
        int          cycles;
        int          guard;
        logic [63:0] expected;
        cycles = 0;
        guard  = 0;
        while (!done && guard < 100) begin
            if (busy) cycles++;
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, "_busy_len"}, 64'(cycles), 64'(exp_busy));
        checkOutput({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        expected = exp_q.pop_front();
        readHiLo(tag, expected);
        if (chain) begin
            dataA  = na;
            dataB  = nb;
            Signal = MULTU;
            start  = 1'b1;
            exp_q.push_back({32'b0, na} * {32'b0, nb});
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
        if (chain) checkOutput({tag, "_chain_busy"}, {63'b0, busy}, 64'd1);
    endtask

    initial begin
        int          dc;
        logic [31:0] ra;
        logic [31:0] rb;
        checks     = 0;
        failures   = 0;
        done_count = 0;
        reset      = 1'b0;
        start      = 1'b0;
        dataA      = '0;
        dataB      = '0;
        Signal     = MFLO;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        readHiLo("reset", 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);

        applyStimulus(32'd3, 32'd5, MULTU, 1);
        waitResult("mul_3x5", 33, 0, 32'd0, 32'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULTU, 1);
        waitResult("mul_ones", 33, 0, 32'd0, 32'd0);

        // A second request arrives at edge 5 and the operand buses change mid-run.
        dc = done_count;
        applyStimulus(32'h0001_0000, 32'h0001_0000, MULTU, 1);
        repeat (4) @(negedge clk);
        dataA  = 32'd7;
        dataB  = 32'd9;
        Signal = MULTU;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataA = 32'hDEAD_BEEF;
        dataB = 32'h1234_5678;
        waitResult("mul_ignore", 28, 0, 32'd0, 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("ignore_done_once", 64'(done_count - dc), 64'd1);
        checkOutput("ignore_idle", {63'b0, busy}, 64'd0);

        // Reset partway through a multiply must abort it and clear HiLo.
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, MULTU, 0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", {63'b0, busy}, 64'd0);
        checkOutput("abort_done", {63'b0, done}, 64'd0);
        readHiLo("abort", 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(32'd6, 32'd7, MULTU, 1);
        waitResult("mul_6x7", 33, 0, 32'd0, 32'd0);

        dc = done_count;
        applyStimulus(32'd11, 32'd13, ADD, 0);
        checkOutput("add_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("add_no_done", 64'(done_count - dc), 64'd0);
        readHiLo("add_hilo", 64'd42);

        applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, MULTU, 1);
        waitResult("b2b_first", 33, 1, 32'hFFFF_FFFF, 32'd2);
        waitResult("b2b_second", 33, 0, 32'd0, 32'd0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb, MULTU, 1);
            waitResult("mul_rand", 33, 0, 32'd0, 32'd0);
        end

        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
